// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared processor constants: NOP encoding, loader FSM states, lane helper.
package imem_responder_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Lanes above the one being written are assumed zero in 'word'.
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [7:0]  data,
                                              input logic [1:0]  lane);
    return word | ({24'd0, data} << {lane, 3'b000});
  endfunction

endpackage

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory with 1-cycle registered fetch and a byte-stream program loader.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_raddr,
  output logic [31:0] o_imem_rdata,
  output logic        o_misaligned,
  input  logic        i_load_start,
  input  logic        i_load_valid,
  input  logic [7:0]  i_load_data,
  input  logic        i_load_last,
  output logic        o_load_ready,
  output logic        o_busy,
  output logic        o_load_done,
  output logic        o_load_err
);

  localparam int           IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH_WORDS);
  localparam logic [32:0]  SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       state;
  logic [IDX_W:0]   word_cnt;
  logic [1:0]       lane_cnt;
  logic [31:0]      word_buf;
  logic             err_q;
  logic [31:0]      ram_q;
  logic             nop_q;
  logic             mis_q;

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] rd_idx;
  logic             busy;
  logic             accept;
  logic             room;
  logic             wr_en;
  logic [31:0]      wr_word;

  // Comparing the byte offset against the byte span avoids dropping offset[1:0].
  assign offset   = i_imem_raddr - BASE_ADDR;
  assign in_range = (i_imem_raddr >= BASE_ADDR) && ({1'b0, offset} < SPAN_BYTES);
  assign rd_idx   = offset[IDX_W+1:2];

  assign busy    = (state != ST_IDLE);
  assign accept  = i_load_valid && (state == ST_LOAD);
  assign room    = (word_cnt < DEPTH_CNT);
  assign wr_word = lane_insert(word_buf, i_load_data, lane_cnt);
  assign wr_en   = accept && room && ((lane_cnt == 2'd3) || i_load_last);

  // Storage has no reset so it maps onto a plain synchronous-read block RAM.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[word_cnt[IDX_W-1:0]] <= wr_word;
    end
  end

  always_ff @(posedge i_clk) begin
    ram_q <= mem[rd_idx];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      lane_cnt <= '0;
      word_buf <= '0;
      err_q    <= 1'b0;
      nop_q    <= 1'b1;
      mis_q    <= 1'b0;
    end else begin
      nop_q <= busy || !in_range;
      mis_q <= !busy && (i_imem_raddr[1:0] != 2'b00);
      case (state)
        ST_IDLE: begin
          if (i_load_start) begin
            state    <= ST_LOAD;
            word_cnt <= '0;
            lane_cnt <= '0;
            word_buf <= '0;
            err_q    <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (!room) begin
              err_q <= 1'b1;
            end else if (wr_en) begin
              word_buf <= '0;
              lane_cnt <= '0;
              word_cnt <= word_cnt + 1'b1;
            end else begin
              word_buf <= wr_word;
              lane_cnt <= lane_cnt + 2'd1;
            end
            if (i_load_last) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_imem_rdata = nop_q ? NOP_INSN : ram_q;
  assign o_misaligned = mis_q;
  assign o_load_ready = (state == ST_LOAD);
  assign o_busy       = busy;
  assign o_load_done  = (state == ST_DONE);
  assign o_load_err   = err_q;

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words stored (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00000000, byte address of word 0.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_imem_raddr  input  32  fetch byte address from the IF stage.
REQ-006 SHALL have port o_imem_rdata  output  32  instruction word for the address presented the previous cycle.
REQ-007 SHALL have port o_misaligned  output  1  previous-cycle address had raddr[1:0] != 0; aligned with o_imem_rdata.
REQ-008 SHALL have port i_load_start  input  1  one-cycle request to begin a program load.
REQ-009 SHALL have port i_load_valid  input  1  load byte valid.
REQ-010 SHALL have port i_load_data  input  8  load byte, little-endian within each word.
REQ-011 SHALL have port i_load_last  input  1  current byte is the final byte of the image.
REQ-012 SHALL have port o_load_ready  output  1  block accepts a load byte this cycle.
REQ-013 SHALL have port o_busy  output  1  load in progress; the core holds its PC stalled or in reset while high.
REQ-014 SHALL have port o_load_done  output  1  one-cycle pulse when a load completes.
REQ-015 SHALL have port o_load_err  output  1  sticky flag: load overflowed DEPTH_WORDS.

Function
REQ-016 SHALL register the read: o_imem_rdata at cycle N+1 reflects mem[index(i_imem_raddr at N)], a latency of exactly 1 cycle.
REQ-017 SHALL compute index = (raddr - BASE_ADDR) >> 2; raddr[1:0] SHALL be ignored for data selection.
REQ-018 SHALL return 32'h00000013 (NOP) when raddr < BASE_ADDR or index >= DEPTH_WORDS.
REQ-019 SHALL return NOP on all reads while o_busy is high, and SHALL force o_misaligned low during that time.
REQ-020 SHALL return identical data on consecutive cycles when the same address is re-presented (stall hold).
REQ-021 SHALL implement the FSM IDLE -> LOAD on i_load_start; LOAD -> DONE when a byte is accepted with i_load_last=1; DONE -> IDLE after one cycle.
REQ-022 SHALL ignore i_load_start in LOAD and DONE.
REQ-023 SHALL assert o_load_ready only in LOAD; a byte is accepted when i_load_valid && o_load_ready.
REQ-024 SHALL assemble bytes into lanes 0..3 via a 2-bit lane counter and write the word to mem[word counter] when lane 3 is filled, then increment the word counter.
REQ-025 SHALL, when the last byte completes a partial word, zero-fill the remaining lanes and write that word.
REQ-026 SHALL discard accepted bytes once the word counter equals DEPTH_WORDS, set o_load_err, and still complete on i_load_last.
REQ-027 SHALL clear o_load_err, the word counter and the lane counter on entry to LOAD.
REQ-028 SHALL assert o_busy in LOAD and DONE, and pulse o_load_done only in DONE.

Reset
REQ-029 SHALL, on i_rst, set the FSM to IDLE, zero both counters, set o_imem_rdata=32'h00000013, and clear o_misaligned, o_load_ready, o_busy, o_load_done and o_load_err.
REQ-030 SHALL retain memory contents across reset, including words written before a mid-load reset; the load is abandoned.

Structure
REQ-031 SHALL take the NOP encoding (32'h00000013) and the FSM state encodings from the shared processor package.
REQ-032 SHALL be a single module with no sub-modules; the storage array SHALL be inferable as synchronous-read block RAM.

Verification
REQ-033 SHALL cover a load of bytes 13 00 00 00 93 00 10 00 (last on the 8th byte), then raddr 0 and 4 -> rdata 0x00000013 then 0x00100093, one cycle after each address; o_load_done pulses once.
REQ-034 SHALL cover a 5-byte load ending with AA -> word 1 reads 0x000000AA.
REQ-035 SHALL cover DEPTH_WORDS=4 with a 20-byte load -> o_load_err=1 after the 17th byte, done on the 20th, words 0..3 intact.
REQ-036 SHALL cover raddr=0x00000006 -> rdata = word 1 with o_misaligned=1; raddr = BASE_ADDR+4*DEPTH_WORDS -> 0x00000013.
REQ-037 SHALL cover i_rst asserted mid-load after 6 bytes -> IDLE, o_busy=0, word 0 retained, word 1 unchanged, rdata=0x00000013.
REQ-038 SHALL cover the same raddr held for 3 cycles (stall) -> rdata constant, and reads during LOAD -> 0x00000013.
